// File: rtl/rr_mux.sv
// rr_mux: NCH-channel round-robin arbitrating mux with a single registered valid/ready output stage.
// Define RR_MUX_LOCK_EN to hold the grant on one channel until that channel's in_last beat.
module rr_mux #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned W    = 4,
    parameter int unsigned SELW = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
`ifdef RR_MUX_LOCK_EN
    input  logic [NCH-1:0]   in_last,
    output logic             out_last,
`endif
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SELW-1:0]  out_ch,
    input  logic             out_ready
);

    if (NCH < 2) begin : g_bad_nch
        $error("rr_mux needs at least two channels");
    end

`ifdef RR_MUX_LOCK_EN
    typedef enum logic {StOpen, StLocked} lock_e;
    lock_e lock_q;
`endif

    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] gnt;
    logic [SELW-1:0] ptr_next;
    logic [W-1:0]    gnt_data;
    logic            any_valid;
    logic            load;
    logic            xfer;

    // Output register can take a beat when empty or draining this cycle.
    assign load     = !out_valid | out_ready;
    assign xfer     = load & any_valid & !rst;
    assign ptr_next = (gnt == SELW'(NCH - 1)) ? '0 : gnt + 1'b1;

    // Rotating priority search starting at ptr_q, wrapping modulo NCH.
    always_comb begin
        int unsigned idx;
        any_valid = 1'b0;
        gnt       = ptr_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!any_valid && in_valid[SELW'(idx)]) begin
                any_valid = 1'b1;
                gnt       = SELW'(idx);
            end
        end
`ifdef RR_MUX_LOCK_EN
        // Mid-packet: only the owning channel may move, whatever else is requesting.
        if (lock_q == StLocked) begin
            gnt       = out_ch;
            any_valid = in_valid[out_ch];
        end
`endif
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (gnt == SELW'(c)) begin
                gnt_data = in_data[c*W +: W];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr_q     <= '0;
`ifdef RR_MUX_LOCK_EN
            lock_q    <= StOpen;
            out_last  <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt;
`ifdef RR_MUX_LOCK_EN
            out_last  <= in_last[gnt];
            if (in_last[gnt]) begin
                lock_q <= StOpen;
                ptr_q  <= ptr_next;
            end else begin
                lock_q <= StLocked;
            end
`else
            ptr_q     <= ptr_next;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux.sv
// Scoreboard bench for rr_mux: a 4-channel and a 3-channel instance, directed stimulus.
module tb_rr_mux;

    localparam int unsigned NCH  = 4;
    localparam int unsigned NCHB = 3;
    localparam int unsigned W    = 4;

    typedef struct packed {
        logic       last;
        logic [1:0] ch;
        logic [3:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NCH-1:0]   in_valid;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [1:0]       out_ch;
    logic             out_ready;

    logic              rst_b;
    logic [NCHB-1:0]   b_in_valid;
    logic [NCHB*W-1:0] b_in_data;
    logic [NCHB-1:0]   b_in_ready;
    logic              b_out_valid;
    logic [W-1:0]      b_out_data;
    logic [1:0]        b_out_ch;
    logic              b_out_ready;

`ifdef RR_MUX_LOCK_EN
    logic [NCH-1:0]  in_last;
    logic            out_last;
    logic [NCHB-1:0] b_in_last;
    logic            b_out_last;
`endif

    rr_mux #(.NCH(NCH), .W(W)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef RR_MUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    rr_mux #(.NCH(NCHB), .W(W)) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
`ifdef RR_MUX_LOCK_EN
        .in_last   (b_in_last),
        .out_last  (b_out_last),
`endif
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ch    (b_out_ch),
        .out_ready (b_out_ready)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t qa[$];
    beat_t qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic last, input logic [1:0] ch, input logic [3:0] d);
        beat_t b;
        b.last = last;
        b.ch   = ch;
        b.data = d;
        qa.push_back(b);
    endtask

    task automatic push_b(input logic [1:0] ch, input logic [3:0] d);
        beat_t b;
        b.last = 1'b1;
        b.ch   = ch;
        b.data = d;
        qb.push_back(b);
    endtask

    // Monitors sample late in the low phase, after stimulus has settled.
    always begin : mon_a
        beat_t e;
        @(negedge clk);
        #3;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_extra_beat: got ch %0d data %0h expected no beat", out_ch, out_data);
            end else begin
                e = qa.pop_front();
                chk("a_out_ch", 32'(out_ch), 32'(e.ch));
                chk("a_out_data", 32'(out_data), 32'(e.data));
`ifdef RR_MUX_LOCK_EN
                chk("a_out_last", 32'(out_last), 32'(e.last));
`endif
            end
        end
    end

    always begin : mon_b
        beat_t e;
        @(negedge clk);
        #3;
        if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_beat: got ch %0d data %0h expected no beat", b_out_ch, b_out_data);
            end else begin
                e = qb.pop_front();
                chk("b_out_ch", 32'(b_out_ch), 32'(e.ch));
                chk("b_out_data", 32'(b_out_data), 32'(e.data));
            end
        end
    end

    initial begin
        logic [3:0] sparse_rdy [3];
        sparse_rdy[0] = 4'b1000;
        sparse_rdy[1] = 4'b0010;
        sparse_rdy[2] = 4'b1000;

        rst         = 1'b1;
        in_valid    = 4'hf;
        in_data     = {4'd3, 4'd2, 4'd1, 4'd0};
        out_ready   = 1'b1;
        rst_b       = 1'b1;
        b_in_valid  = '0;
        b_in_data   = {4'd9, 4'd8, 4'd7};
        b_out_ready = 1'b1;
`ifdef RR_MUX_LOCK_EN
        in_last   = '1;
        b_in_last = '1;
`endif

        // Reset held two cycles with every channel requesting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
`ifdef RR_MUX_LOCK_EN
        chk("rst_out_last", 32'(out_last), 0);
`endif

        // Fairness: all valid, grants 0,1,2,3,0,1 back to back.
        for (int i = 0; i < 6; i++) begin
            push_a(1'b1, 2'(i % 4), 4'(i % 4));
        end
        rst = 1'b0;
        #1;
        chk("first_grant_rdy", 32'(in_ready), 32'h1);
        repeat (6) @(negedge clk);
        in_valid = '0;
        @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 0);
        chk("drain_out_ch_held", 32'(out_ch), 1);
        chk("drain_out_data_held", 32'(out_data), 1);

        // Sparse: ptr is now 2, channels 1 and 3 requesting -> 3, 1, 3.
        push_a(1'b1, 2'd3, 4'd3);
        push_a(1'b1, 2'd1, 4'd1);
        push_a(1'b1, 2'd3, 4'd3);
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sparse_rdy", 32'(in_ready), 32'(sparse_rdy[i]));
            @(negedge clk);
        end
        in_valid = '0;
        @(negedge clk);

        // Back-pressure: ptr is 0, load channel 0 then stall three cycles.
        push_a(1'b1, 2'd0, 4'ha);
        push_a(1'b1, 2'd2, 4'd2);
        in_data   = {4'd3, 4'd2, 4'd1, 4'ha};
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        #1;
        chk("bp_load_rdy", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_data", 32'(out_data), 32'ha);
            chk("bp_out_ch", 32'(out_ch), 0);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'h4);
        @(negedge clk);
        chk("bp_no_bubble_valid", 32'(out_valid), 1);
        chk("bp_no_bubble_ch", 32'(out_ch), 2);
        in_valid = '0;
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 0);

        // Reset with a stalled beat held: the beat is dropped, nothing accepted.
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_out_ch", 32'(out_ch), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = '0;

`ifdef RR_MUX_LOCK_EN
        // Packet lock: move ptr to 1, then channel 2 sends three beats while channel 0 waits.
        push_a(1'b1, 2'd0, 4'ha);
        in_valid = 4'b0001;
        @(negedge clk);
        in_valid = 4'b0101;
        in_last  = 4'b1011;
        in_data  = {4'd3, 4'd4, 4'd1, 4'ha};
        push_a(1'b0, 2'd2, 4'd4);
        #1;
        chk("lock_rdy_1", 32'(in_ready), 32'h4);
        @(negedge clk);
        in_data = {4'd3, 4'd5, 4'd1, 4'ha};
        push_a(1'b0, 2'd2, 4'd5);
        #1;
        chk("lock_rdy_2", 32'(in_ready), 32'h4);
        @(negedge clk);
        in_data = {4'd3, 4'd6, 4'd1, 4'ha};
        in_last = 4'b1111;
        push_a(1'b1, 2'd2, 4'd6);
        #1;
        chk("lock_rdy_3", 32'(in_ready), 32'h4);
        @(negedge clk);
        in_valid = 4'b0001;
        push_a(1'b1, 2'd0, 4'ha);
        #1;
        chk("lock_release_rdy", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = '0;
        @(negedge clk);
`endif

        // Three channels, all valid: 0,1,2,0,1,2,0 with explicit wrap.
        for (int i = 0; i < 7; i++) begin
            push_b(2'(i % 3), 4'(7 + i % 3));
        end
        rst_b      = 1'b0;
        b_in_valid = '1;
        #1;
        chk("b_first_rdy", 32'(b_in_ready), 32'h1);
        repeat (7) @(negedge clk);
        b_in_valid = '0;
        repeat (3) @(negedge clk);

        chk("a_queue_empty", 32'(qa.size()), 0);
        chk("b_queue_empty", 32'(qb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-channel, W-bit round-robin arbitrating multiplexer with a valid/ready handshake on every input and on the output. It generalises the team's fixed 4:1 combinational data mux. The select comes from an internal fair arbiter instead of an external `s` input, and the result is registered. It sits between several independent producers and one shared consumer, for example several sources feeding one display or UART path.

## Interface
Parameters:
- `NCH`, default 4: number of input channels, minimum 2.
- `W`, default 4: data width per channel.
- `SELW`, default `$clog2(NCH)`: width of the channel index.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `in_valid`  input  NCH: per-channel request; bit c belongs to channel c.
- `in_data`  input  NCH*W: flat data bus; channel c is `in_data[c*W +: W]`.
- `in_ready`  output  NCH: per-channel accept, one-hot or zero.
- `out_valid`  output  1: output register holds a beat.
- `out_data`  output  W: registered data.
- `out_ch`  output  SELW: index of the channel that produced `out_data`.
- `out_ready`  input  1: consumer accept.
- `in_last`  input  NCH: end-of-packet marker per channel. Present only with `RR_MUX_LOCK_EN`.
- `out_last`  output  1: registered copy of the granted `in_last`. Present only with `RR_MUX_LOCK_EN`.

## Operation
- **Load enable:** `load = !out_valid | out_ready`. The single output register can take a new beat when it is empty or when it is being drained in the same cycle.
- **Arbitration:** combinational. The grant goes to the first channel with `in_valid` high, searching c = ptr, ptr+1, … NCH-1, 0, … ptr-1 with modulo-NCH wrap.
- **Handshake signals:**
  - `in_ready[g] = load & any_valid`, where g is the granted channel. All other `in_ready` bits are 0.
  - `in_ready` never depends on `in_valid` of another channel being low.
- **Transfer:** a transfer on channel g occurs when `in_valid[g] & in_ready[g]`. On the next edge:
  - `out_data` ← channel g's data,
  - `out_ch` ← g,
  - `out_valid` ← 1,
  - `ptr` ← (g+1) mod NCH.
- **Drain without refill:** `out_valid & out_ready` with no new transfer → `out_valid` ← 0. `out_data` and `out_ch` keep their last values.
- **Output stability:** while `out_valid & !out_ready`, `out_data`, `out_ch` and `ptr` are held stable, and all `in_ready` bits are 0.
- **Idle:** no `in_valid` bit high → `ptr` unchanged, no transfer.
- **Pointer update (non-power-of-two NCH):** `ptr` wraps explicitly from NCH-1 to 0. It never takes a value ≥ NCH.
- **Fairness:** with all NCH channels continuously valid and `out_ready` tied high, the grants cycle 0,1,…,NCH-1,0,… with no repeats.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0, lock state idle, `out_last`=0. During `rst`, `in_ready`=0.
- **Reset mid-operation:** a held output beat is discarded and no input is accepted in the reset cycle.
- **Latency:** one cycle from input transfer to `out_valid`.
- **Throughput:** one beat per cycle when `out_ready` is held high.
- **Back-pressure:** zero bubbles; the output register is refilled in the same cycle it drains.
- **Combinational paths:** `in_valid`→`in_ready` and `out_ready`→`in_ready` are combinational. There is no combinational path from any input to `out_valid`, `out_data` or `out_ch`.

## Configuration
- **`RR_MUX_LOCK_EN` defined:** packet lock.
  - After a transfer on channel g with `in_last[g]`=0, the arbiter locks to g.
  - While locked, `in_ready` can assert only for g; other channels are ignored even if valid.
  - `ptr` does not advance while locked.
  - The lock releases on the edge that transfers a beat with `in_last[g]`=1, and `ptr` ← (g+1) mod NCH.
  - `out_last` is registered alongside `out_data`.
- **`RR_MUX_LOCK_EN` undefined:** arbitration happens every beat. `in_last` and `out_last` ports do not exist.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all `in_valid`=1 → `out_valid`=0, `out_data`=0, `out_ch`=0, `in_ready`=0; the first grant after release goes to channel 0.
- **Fairness:** NCH=4, W=4, channel c data = c (0000, 0001, 0010, 0011), all valid, `out_ready`=1 → `out_ch` sequence 0,1,2,3,0,1 and `out_data` matches 0000, 0001, 0010, 0011, 0000, 0001, one beat per cycle.
- **Sparse request:** only channels 1 and 3 valid, `ptr`=2 → grant 3, then 1, then 3; channels 0 and 2 never see `in_ready`.
- **Back-pressure:** hold `out_ready`=0 for 3 cycles with `out_valid`=1 → `out_data`/`out_ch` stable and `in_ready`=0; on release, a new beat is loaded in the same cycle (no bubble).
- **Non-power-of-two:** NCH=3, all channels valid → grants 0,1,2,0; `ptr` never reaches 3.
- **Packet lock (`RR_MUX_LOCK_EN`):** channel 2 sends 3 beats with `in_last`=0,0,1 while channel 0 is valid → 3 consecutive grants to channel 2, then channel 0; `out_last`=1 only on the third beat.
